// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared definitions for the immediate encoder and the
//                immediate-extension stage: extension-mode codes, encoder
//                state encoding and a reference expansion helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Extension modes carried alongside every 16-bit immediate.
    localparam logic [1:0] IMM_SEXT = 2'b00;   // sign-extend imm16
    localparam logic [1:0] IMM_ZEXT = 2'b01;   // zero-extend imm16
    localparam logic [1:0] IMM_LUI  = 2'b10;   // imm16 into the upper half

    // Encoder sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // waiting for a constant
        SINGLE = 2'd1,   // one self-contained beat pending
        HI     = 2'd2,   // load-upper beat of a pair pending
        LO     = 2'd3    // OR-in lower beat of a pair pending
    } enc_state_e;

    // Expansion of one beat as the extension stage performs it. Mode 2'b11
    // is unused and expands to zero.
    function automatic logic [31:0] imm_expand(input logic [15:0] imm,
                                               input logic [1:0]  mode);
        logic [31:0] result;
        result = 32'd0;
        case (mode)
            IMM_SEXT: result = {{16{imm[15]}}, imm};
            IMM_ZEXT: result = {16'd0, imm};
            IMM_LUI:  result = {imm, 16'd0};
            default:  result = 32'd0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_classify.sv
`default_nettype none
// ============================================================================
//  Module      : imm_classify
//  Description : Combinational classifier deciding whether a 32-bit constant
//                fits a single extension beat, and with which mode/immediate.
//                Sign-extension wins over zero-extension, which wins over
//                load-upper, so zero encodes as a sign-extended 0x0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_classify
    import imm_pkg::*;
(
    input  logic [31:0] value_i,
    output logic        is_single_o,
    output logic [1:0]  single_mode_o,
    output logic [15:0] single_imm_o
);

    logic w_fits_sext;
    logic w_fits_zext;
    logic w_fits_lui;

    // Bits 31..15 identical means the low half sign-extends to the value.
    assign w_fits_sext = (&value_i[31:15]) | ~(|value_i[31:15]);
    assign w_fits_zext = ~(|value_i[31:16]);
    assign w_fits_lui  = ~(|value_i[15:0]);

    // Priority selection of the single-beat encoding.
    always_comb begin
        is_single_o   = 1'b1;
        single_mode_o = IMM_SEXT;
        single_imm_o  = value_i[15:0];
        if (w_fits_sext) begin
            single_mode_o = IMM_SEXT;
            single_imm_o  = value_i[15:0];
        end else if (w_fits_zext) begin
            single_mode_o = IMM_ZEXT;
            single_imm_o  = value_i[15:0];
        end else if (w_fits_lui) begin
            single_mode_o = IMM_LUI;
            single_imm_o  = value_i[31:16];
        end else begin
            is_single_o   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Compresses a 32-bit constant into one or two (imm16, mode)
//                beats that the immediate-extension stage expands back to the
//                original value. A two-beat sequence is a load-upper beat
//                followed by a zero-extended lower half OR-ed into it.
//                Valid/ready handshake on both sides; all beat fields are
//                registered and held stable while stalled.
//  Options     : IMM_ENC_STATS_EN - adds saturating beat counters
//                stat_single / stat_double of width STAT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned STAT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm16,
    output logic [1:0]  out_mode,
    output logic        out_combine,
    output logic        out_last
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_single,
    output logic [STAT_W-1:0] stat_double
`endif
);

    // Counter width must be meaningful even when the counters are built out.
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("imm_encoder: STAT_W must be at least 1");
    end

    enc_state_e  state_q;
    logic        out_valid_q;
    logic [15:0] out_imm16_q;
    logic [1:0]  out_mode_q;
    logic        out_combine_q;
    logic        out_last_q;
    // Only the lower half of the accepted constant is needed after accept:
    // the upper half is already loaded into the first beat.
    logic [15:0] lo_half_q;

    logic        w_accept;
    logic        w_beat_done;
    logic        w_is_single;
    logic [1:0]  w_single_mode;
    logic [15:0] w_single_imm;

    imm_classify u_classify (
        .value_i       (in_value),
        .is_single_o   (w_is_single),
        .single_mode_o (w_single_mode),
        .single_imm_o  (w_single_imm)
    );

    // Accept only in IDLE and never while reset is asserted.
    assign in_ready    = (state_q == IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_beat_done = out_valid_q && out_ready;

    assign out_valid   = out_valid_q;
    assign out_imm16   = out_imm16_q;
    assign out_mode    = out_mode_q;
    assign out_combine = out_combine_q;
    assign out_last    = out_last_q;

    // Sequencer: accept/classify, present beats, advance on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_imm16_q   <= 16'd0;
            out_mode_q    <= IMM_SEXT;
            out_combine_q <= 1'b0;
            out_last_q    <= 1'b0;
            lo_half_q     <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        lo_half_q     <= in_value[15:0];
                        out_valid_q   <= 1'b1;
                        out_combine_q <= 1'b0;
                        if (w_is_single) begin
                            state_q     <= SINGLE;
                            out_imm16_q <= w_single_imm;
                            out_mode_q  <= w_single_mode;
                            out_last_q  <= 1'b1;
                        end else begin
                            state_q     <= HI;
                            out_imm16_q <= in_value[31:16];
                            out_mode_q  <= IMM_LUI;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                SINGLE: begin
                    if (w_beat_done) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                HI: begin
                    // Lower half follows directly; out_valid stays high.
                    if (w_beat_done) begin
                        state_q       <= LO;
                        out_imm16_q   <= lo_half_q;
                        out_mode_q    <= IMM_ZEXT;
                        out_combine_q <= 1'b1;
                        out_last_q    <= 1'b1;
                    end
                end
                LO: begin
                    if (w_beat_done) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic [STAT_W-1:0] stat_single_q;
    logic [STAT_W-1:0] stat_double_q;

    // Saturating counts of completed single-beat and two-beat constants.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_single_q <= '0;
            stat_double_q <= '0;
        end else if (w_beat_done) begin
            if ((state_q == SINGLE) && !(&stat_single_q)) begin
                stat_single_q <= stat_single_q + 1'b1;
            end
            if ((state_q == LO) && !(&stat_double_q)) begin
                stat_double_q <= stat_double_q + 1'b1;
            end
        end
    end

    assign stat_single = stat_single_q;
    assign stat_double = stat_double_q;
`endif

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate-extension stage: compresses a 32-bit constant into one or two (imm16, mode) beats that the extension stage expands back to the original value.
- Sits between the constant/assembler front end and instruction emission.
- Uses a valid/ready handshake on both sides.
- A two-beat sequence is a load-upper beat followed by an OR-in of the lower half.

Parameters:
- STAT_W, 16: width of the statistics counters; used only when IMM_ENC_STATS_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_value is offered
- in_ready  output  1  encoder can accept a constant
- in_value  input  32  constant to encode
- out_valid  output  1  beat is presented
- out_ready  input  1  consumer takes the beat
- out_imm16  output  16  immediate field of the beat
- out_mode  output  2  00 sign-extend, 01 zero-extend, 10 load-upper
- out_combine  output  1  0 = beat loads the destination; 1 = beat ORs into the previous beat's result
- out_last  output  1  final beat for this constant

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid=0, out_imm16=0, out_mode=00, out_combine=0, out_last=0, stored value=0. in_ready=0 while rst=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SINGLE: one beat pending.
  - HI: upper beat pending.
  - LO: lower beat pending.
- Accept: when in_valid&&in_ready, register in_value and classify.
- Classification, first match wins:
  - (a) in_value[31:15] all equal -> SINGLE, mode 00, imm=[15:0].
  - (b) in_value[31:16]==0 -> SINGLE, mode 01, imm=[15:0].
  - (c) in_value[15:0]==0 -> SINGLE, mode 10, imm=[31:16].
  - (d) otherwise -> HI.
- Beat contents:
  - SINGLE beat: out_last=1, out_combine=0.
  - HI beat: imm=[31:16], mode 10, combine 0, last 0.
  - LO beat: imm=[15:0], mode 01, combine 1, last 1.
- Latency: first beat's out_valid rises the cycle after accept.
- Sequence transitions:
  - A beat completes on out_valid&&out_ready.
  - HI completes -> LO on the next cycle.
  - SINGLE or LO completes -> IDLE on the next cycle; in_ready=1 that cycle.
  - No back-to-back accept in the completion cycle, so at most one constant per 2 cycles (single) or 3 cycles (double).
- Stall: while out_valid&&!out_ready, all out_* fields hold stable. out_valid never drops without a handshake.
- in_value is ignored outside IDLE. The stored value is not altered until the next accept.
- Reset mid-sequence: the sequence is abandoned. Next cycle: IDLE, out_valid=0, in_ready=1 once rst deasserts. No partial beat is replayed.
- Invariant: expanding the beats per out_mode and OR-combining where out_combine=1 reproduces in_value exactly.

Optional Feature:
- Macro: IMM_ENC_STATS_EN.
- Defined: adds outputs stat_single and stat_double, each STAT_W bits.
  - stat_single increments on each completed SINGLE beat; stat_double increments on each completed LO beat.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package imm_pkg:
  - Mode constants IMM_SEXT=2'b00, IMM_ZEXT=2'b01, IMM_LUI=2'b10.
  - Encoder state enum {IDLE, SINGLE, HI, LO}.
  - The extension stage imports the same mode constants.
- One sub-module, imm_classify: purely combinational. Inputs: 32-bit value. Outputs: is_single, single_mode, single_imm.

Test Plan:
- in_value=0xFFFF8000, out_ready=1 -> one beat: imm 0x8000, mode 00, last 1, combine 0. in_ready high again 2 cycles after accept.
- in_value=0x0000ABCD -> one beat: imm 0xABCD, mode 01, last 1 (sign-fit fails because bit15=1). in_value=0x00000000 -> imm 0x0000, mode 00 (priority rule).
- in_value=0x12340000 -> one beat: imm 0x1234, mode 10, last 1.
- in_value=0x12345678 with out_ready low for 3 cycles on each beat:
  - Beat 1: 0x1234/10/combine0/last0, held stable through the stall.
  - Beat 2: 0x5678/01/combine1/last1.
  - in_ready stays 0 throughout. Re-expansion equals 0x12345678.
- rst asserted for 1 cycle during HI stall of 0xDEADBEEF -> next cycle out_valid=0 and state IDLE. A subsequent in_value=0x7 gives imm 0x0007, mode 00.
- With IMM_ENC_STATS_EN and STAT_W=2: 5 single constants -> stat_single saturates at 3. 1 double constant -> stat_double=1.
